// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Address split: word offset [1:0], index [3:2], tag [31:4].
package dcache_pkg;

  localparam int LINES   = 4;
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 32 - INDEX_W - 2;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [TAG_W-1:0]   tag_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  // Line index of a byte address.
  function automatic index_t get_index(input logic [31:0] addr);
    return index_t'(addr >> 2);
  endfunction

  // Tag of a byte address.
  function automatic tag_t get_tag(input logic [31:0] addr);
    return tag_t'(addr >> (INDEX_W + 2));
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the data cache: valid/dirty bits (cleared by reset)
// plus tag and data arrays. One combinational read port, one write port
// with independent data/tag enables and set/clear dirty strobes.
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // read port
  input  index_t      rd_idx,
  output logic        rd_valid,
  output logic        rd_dirty,
  output tag_t        rd_tag,
  output logic [31:0] rd_data,
  // write port
  input  index_t      wr_idx,
  input  logic        wr_data_en,
  input  logic [31:0] wr_data,
  input  logic        wr_tag_en,
  input  tag_t        wr_tag,
  input  logic        set_dirty,
  input  logic        clr_dirty
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  tag_t             tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Status bits: reset invalidates every line; a tag write validates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_tag_en) valid_q[wr_idx] <= 1'b1;
      if (set_dirty)      dirty_q[wr_idx] <= 1'b1;
      else if (clr_dirty) dirty_q[wr_idx] <= 1'b0;
    end
  end

  // Tag and data arrays.
  // NOTE: no reset on the arrays -- contents are meaningless while valid is 0,
  // and leaving them unreset lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_tag_en)  tag_q[wr_idx]  <= wr_tag;
    if (wr_data_en) data_q[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits complete in the same cycle; misses stall, write back a dirty victim
// if present, refill over the req/ack port, then replay the access.
// Optional macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
module data_cache
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t      state_q, state_d;
  index_t      idx;
  tag_t        req_tag;
  logic        line_valid, line_dirty;
  tag_t        line_tag;
  logic [31:0] line_data;
  logic        hit;

  logic        wr_data_en, wr_tag_en, set_dirty, clr_dirty;
  logic [31:0] wr_data;

  // Byte-offset bits play no part in a word-only cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign idx     = get_index(cpu_addr);
  assign req_tag = get_tag(cpu_addr);
  assign hit     = cpu_req && line_valid && (line_tag == req_tag);

  dcache_line_store u_store (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (idx),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .wr_idx     (idx),
    .wr_data_en (wr_data_en),
    .wr_data    (wr_data),
    .wr_tag_en  (wr_tag_en),
    .wr_tag     (req_tag),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty)
  );

  // State register; reset aborts any memory transaction at once.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) is kept for the combinational block below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, CPU/memory outputs and line-store write strobes.
  // NOTE: every output gets a default first so no path leaves a value held,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_data_en = 1'b0;
    wr_data    = cpu_wdata;
    wr_tag_en  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = line_data;
            if (cpu_we) begin
              wr_data_en = 1'b1;
              set_dirty  = 1'b1;
            end
          end else begin
            stall   = 1'b1;
            state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx, 2'b00};
        mem_wdata = line_data;
        if (mem_ack) begin
          clr_dirty = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[31:2], 2'b00};
        if (mem_ack) begin
          wr_data_en = 1'b1;
          wr_data    = mem_rdata;
          wr_tag_en  = 1'b1;
          clr_dirty  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep the pipeline released while reset is held, even with a request up.
    if (reset) begin
      stall     = 1'b0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay_q;
  logic idle_hit, idle_miss;

  assign idle_hit  = (state_q == IDLE) && hit;
  assign idle_miss = (state_q == IDLE) && cpu_req && !hit;

  // Hit/miss counters; the replay that completes a miss is not a fresh hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay_q   <= 1'b0;
    end else begin
      if (idle_miss)             miss_count <= miss_count + 32'd1;
      if (idle_hit && !replay_q) hit_count  <= hit_count + 32'd1;
      if (state_q == REFILL && mem_ack) replay_q <= 1'b1;
      else if (state_q == IDLE)         replay_q <= 1'b0;
    end
  end
`else
  // Statistics build option off: no counters, no replay flag.
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a flat reference memory gives the
// expected load data (pushed to a scoreboard queue at issue, popped on
// cpu_ready); a reactive backing memory answers mem_req after a set delay.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  assign mem_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference (CPU-visible) memory and backing memory, both word-addressed.
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] back_mem [logic [31:0]];
  logic [31:0] sb_q [$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] back_read(input logic [31:0] a);
    return back_mem.exists(a) ? back_mem[a] : init_val(a);
  endfunction

  // Backing memory responder: ack on cycle N of a request (N inclusive).
  int          wb_delay = 2, rf_delay = 3;
  int          req_cycles = 0, tot_req_cycles = 0;
  int          n_wb = 0, n_rf = 0;
  logic [31:0] last_wb_addr = '0, last_wb_data = '0, last_rf_addr = '0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      resp_ack = 1'b0;
      if (reset || !mem_req) begin
        req_cycles = 0;
      end else begin
        req_cycles++;
        tot_req_cycles++;
        if (req_cycles == 1) begin
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
        end else begin
          check("mem_addr_stable", mem_addr, hold_addr);
          if (mem_we) check("mem_wdata_stable", mem_wdata, hold_wdata);
        end
        if (req_cycles >= (mem_we ? wb_delay : rf_delay)) begin
          resp_ack = 1'b1;
          if (mem_we) begin
            back_mem[mem_addr] = mem_wdata;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            n_wb++;
          end else begin
            mem_rdata    = back_read(mem_addr);
            last_rf_addr = mem_addr;
            n_rf++;
          end
          req_cycles = 0;
        end
      end
    end
  end

  // One CPU access: issue, count stall cycles, pop/compare on cpu_ready.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_stall, input string name);
    int          stalls = 0;
    bit          done = 0;
    logic [31:0] waddr;
    logic [31:0] exp;
    waddr = {addr[31:2], 2'b00};
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) sb_q.push_back(ref_read(waddr));
    else     ref_mem[waddr] = wdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cpu_ready) begin
        done = 1;
        check({name, "_stall_at_ready"}, 32'(stall), 32'd0);
        check({name, "_mem_req_at_ready"}, 32'(mem_req), 32'd0);
        if (!we) begin
          if (sb_q.size() == 0) check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
          else begin
            exp = sb_q.pop_front();
            check({name, "_rdata"}, cpu_rdata, exp);
          end
        end
      end else if (stall) begin
        stalls++;
      end else begin
        check({name, "_ready_or_stall"}, 32'(cpu_ready), 32'd1);
        done = 1;
      end
    end
    if (!done) check({name, "_timeout"}, 32'(cpu_ready), 32'd1);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int prev_rf, prev_req;

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    back_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10]  = 32'hDEAD_BEEF;

    // Reset values.
    #12;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_stall",     32'(stall),     32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_cpu_rdata", cpu_rdata,      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold load miss, Nr = 3: four stall cycles, no write-back.
    rf_delay = 3;
    access(1'b0, 32'h10, '0, 4, "cold_load");
    check("cold_wb_count", n_wb, 0);
    check("cold_rf_addr", last_rf_addr, 32'h10);
    access(1'b0, 32'h10, '0, 0, "cold_rehit");

    // Store hit: same-cycle completion, no memory traffic.
    prev_rf = n_rf; prev_req = tot_req_cycles;
    access(1'b1, 32'h10, 32'h1234_5678, 0, "store_hit");
    access(1'b0, 32'h10, '0, 0, "load_after_store");
    check("store_no_mem_req", tot_req_cycles, prev_req);
    check("store_no_refill", n_rf, prev_rf);

    // Dirty eviction: Nw = 2, Nr = 3 -> 6 stall cycles.
    wb_delay = 2; rf_delay = 3;
    access(1'b0, 32'h20, '0, 6, "dirty_evict");
    check("evict_wb_count", n_wb, 1);
    check("evict_wb_addr", last_wb_addr, 32'h10);
    check("evict_wb_data", last_wb_data, 32'h1234_5678);
    check("evict_rf_addr", last_rf_addr, 32'h20);
    // Clean miss back to 0x10 proves the written-back word reached memory.
    rf_delay = 1;
    access(1'b0, 32'h10, '0, 2, "reload_evicted");

    // Index aliasing on line 1 with ack in the first request cycle.
    access(1'b0, 32'h04, '0, 2, "alias_first");
    access(1'b0, 32'h14, '0, 2, "alias_second");
    check("alias_rf_addr", last_rf_addr, 32'h14);
    access(1'b0, 32'h14, '0, 0, "alias_tag_hit");

    // A stray ack while idle must not start anything.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    check("stray_ack_mem_req", 32'(mem_req), 32'd0);
    access(1'b0, 32'h14, '0, 0, "stray_ack_hit");

    // Store miss (byte offset ignored), then a dirty miss with Nw = Nr = 1.
    rf_delay = 2;
    access(1'b1, 32'h107, 32'hCAFE_F00D, 3, "store_miss");
    access(1'b0, 32'h104, '0, 0, "store_miss_readback");
    wb_delay = 1; rf_delay = 1;
    access(1'b0, 32'h24, '0, 3, "dirty_fast");
    check("fast_wb_addr", last_wb_addr, 32'h104);
    check("fast_wb_data", last_wb_data, 32'hCAFE_F00D);

    // Reset in the middle of a refill.
    rf_delay = 20;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_mem_req", 32'(mem_req), 32'd0);
    check("mid_reset_stall",   32'(stall),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    rf_delay = 3;
    access(1'b0, 32'h10, '0, 4, "post_reset_miss");

`ifdef DCACHE_STATS_EN
    // Counters: miss (with its replay), then two genuine hits.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 32'h30, '0, 4, "stats_miss");
    access(1'b0, 32'h30, '0, 0, "stats_hit1");
    access(1'b0, 32'h30, '0, 0, "stats_hit2");
    @(negedge clk);
    check("miss_count", miss_count, 32'd1);
    check("hit_count",  hit_count,  32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between `MEM_Stage` and backing data memory. It takes the ALU-computed address from the EX/MEM boundary, splits it into index `[3:2]` and tag `[31:4]`, and answers loads and stores in the same cycle on a hit. On a miss it holds the pipeline with `stall`, writes back a dirty victim if needed, refills the line over a req/ack memory port, then replays the access.

## Interface
- `LINES`, 4: number of one-word lines; index width = log2(LINES) = 2.
- `TAG_W`, 28: tag width, taken from address bits `[31:4]`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: access valid this cycle.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address; bits `[1:0]` are ignored (word access only).
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data, valid when `cpu_ready` is 1.
- `cpu_ready` out 1: access completes this cycle.
- `stall` out 1: freeze IF through MEM.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = write-back, 0 = refill read.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: victim data.
- `mem_rdata` in 32: refill data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse.

## Operation
- Per line: `valid`, `dirty`, `tag[27:0]`, `data[31:0]`.
- FSM states: IDLE, WRITEBACK, REFILL.
- **Hit (IDLE).** A hit is `cpu_req`, `valid[idx]`, and `tag[idx] == cpu_addr[31:4]`. Both `cpu_ready` and `cpu_rdata = data[idx]` are driven combinationally and `stall` = 0.
  - A store hit writes `data[idx]` at the clock edge and sets `dirty[idx]`.
- **Miss (IDLE).** `stall` = 1 combinationally and `cpu_ready` = 0.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- **WRITEBACK.** Drive `mem_req` = 1, `mem_we` = 1, `mem_addr = {tag[idx], idx, 2'b00}`, `mem_wdata = data[idx]`.
  - On `mem_ack`, clear `dirty[idx]` and go to REFILL.
- **REFILL.** Drive `mem_req` = 1, `mem_we` = 0, `mem_addr = {cpu_addr[31:2], 2'b00}`.
  - On `mem_ack`, load `data[idx] = mem_rdata`, set `tag[idx]`, `valid[idx]` = 1, `dirty[idx]` = 0, and go to IDLE.
- **Replay.** Back in IDLE the held request hits and completes; a store replay sets `dirty`.
- `stall` = 1 in every WRITEBACK and REFILL cycle.
- The CPU must hold `cpu_req`, `cpu_we`, `cpu_addr` and `cpu_wdata` stable while `stall` = 1. If `cpu_req` drops mid-miss, the refill still completes and nothing is replayed.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values:
  - All `valid` and `dirty` bits = 0; state = IDLE.
  - `mem_req`, `mem_we`, `cpu_ready`, `stall` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata` = 0.
- Reset asserted mid-miss aborts immediately: `mem_req` drops asynchronously and dirty victim data is lost.
- Hit latency is 0 cycles (same-cycle `cpu_ready`).
- Clean-miss latency is Nr + 1 cycles; dirty-miss latency is Nw + Nr + 1 cycles. Nw and Nr are the cycles from `mem_req` rising to `mem_ack` inclusive.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from assertion until the `mem_ack` edge.
  - After a write-back ack, `mem_req` stays 1 for the refill with no idle gap.
  - After a refill ack, `mem_req` is 0 the next cycle.
- `mem_ack` in the first cycle of `mem_req` is legal, giving Nr = 1.

## Configuration
- `DCACHE_STATS_EN` defined adds outputs `hit_count[31:0]` and `miss_count[31:0]`, both reset to 0 and wrapping at 2^32.
  - `miss_count` increments on each IDLE miss detection.
  - `hit_count` increments on IDLE hits that are not post-refill replays; a `replay` flag is set on refill ack and cleared in IDLE.
- `DCACHE_STATS_EN` undefined: the counters, the `replay` flag and both ports are absent.

## Structure
- `dcache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, REFILL);
  - the `INDEX_W` and `TAG_W` constants;
  - the index and tag extraction helpers.
- One sub-module, `dcache_line_store`, holds the valid/dirty/tag/data arrays with asynchronous clear. It has one combinational read port and one write port, with separate set-dirty and clear-dirty strobes.
- The top level holds the FSM, hit compare and output muxing.

## Test plan
- **Cold load miss.** Load 0x0000_0010 with memory returning 0xDEAD_BEEF after 3 cycles: `stall` lasts 4 cycles, there is no write-back, `cpu_rdata` = 0xDEAD_BEEF, and `valid[0]` = 1.
- **Store hit, no memory traffic.** Store 0x1234_5678 to 0x10 (hit): `cpu_ready` in the same cycle, `stall` = 0, `dirty[0]` = 1, `mem_req` never asserted. A following load of 0x10 returns 0x1234_5678.
- **Dirty eviction.** With line 0 dirty (tag 0x0000001), load 0x0000_0020:
  - write-back with `mem_addr` = 0x0000_0010 and `mem_wdata` = 0x1234_5678;
  - then refill from 0x0000_0020;
  - total stall = Nw + Nr + 1.
- **Index aliasing.** Load 0x04 then 0x14 (both index 1): the second access misses and refills, and line 1's tag becomes 0x0000001.
- **Reset mid-refill.** Assert `reset` during REFILL: `mem_req` = 0 and `stall` = 0 immediately, all lines invalid, and a next load of 0x10 misses.
- **Counters (`DCACHE_STATS_EN`).** Sequence miss, replay, hit, hit: `miss_count` = 1, `hit_count` = 2.
